// File: rtl/common_types.sv
// Shared register-file types and defaults: word/address types and the clear FSM encoding.
package common_types;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_DATA_W   = 32;
  localparam int RF_AW       = $clog2(RF_NUM_REGS);

  typedef logic [RF_DATA_W-1:0] word_t;
  typedef logic [RF_AW-1:0]     rf_addr_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;
endpackage

// File: rtl/dyt_rf_scoreboard.sv
// Per-register busy bits: reserve at issue, release on write commit, bulk drop on flush/clear.
// Ready is combinational; a busy destination stalls unless it is being written this same cycle.
module dyt_rf_scoreboard
  import common_types::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_sel,
  input  logic                rel_en,
  input  logic [AW-1:0]       rel_sel,
  input  logic                flush,
  input  logic                clr_start,
  input  logic                hold,
  output logic                rsv_ready,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  assign rsv_ready = !hold && !flush &&
                     (!r_busy[rsv_sel] || (rel_en && (rel_sel == rsv_sel)));

  // Release first so a same-cycle reservation to the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rel_en) begin
      w_busy_nxt[rel_sel] = 1'b0;
    end
    if (rsv_en && rsv_ready && (rsv_sel != '0)) begin
      w_busy_nxt[rsv_sel] = 1'b1;
    end
    if (flush || clr_start) begin
      w_busy_nxt = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;
endmodule

// File: rtl/dyt_scoreboard_regfile.sv
// Multi-read register file with reservation scoreboard, optional write forwarding and
// a sequential clear engine; reg 0 is hardwired to zero.
module dyt_scoreboard_regfile
  import common_types::*;
#(
  parameter int  DATA_W   = RF_DATA_W,
  parameter int  NUM_REGS = RF_NUM_REGS,
  parameter int  NUM_RD   = 3,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NUM_RD*AW-1:0]     rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wen,
  input  logic [AW-1:0]            w_sel,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_sel,
  output logic                     rsv_ready,
  input  logic                     flush,
  input  logic                     clr_req,
  output logic                     clr_busy
);
  clr_state_t          r_state;
  clr_state_t          w_state_nxt;
  logic [AW-1:0]       r_cnt;
  logic [AW-1:0]       w_cnt_nxt;
  logic                w_clr_start;
  logic                w_commit;
  logic [NUM_REGS-1:0] w_busy;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  assign clr_busy = (r_state == CLR_CLEAR);
  assign w_commit = wen && (w_sel != '0) && !clr_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_start = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLR_CLEAR;
          w_cnt_nxt   = AW'(1);
          w_clr_start = 1'b1;
        end
      end
      CLR_CLEAR: begin
        if (r_cnt == AW'(NUM_REGS - 1)) begin
          w_state_nxt = CLR_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_nxt = CLR_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clearing owns the write port; user writes are dropped until it finishes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (clr_busy) begin
      r_regs[r_cnt] <= '0;
    end else if (w_commit) begin
      r_regs[w_sel] <= w_data;
    end
  end

  dyt_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_sb (
    .CLK       (CLK),
    .nRST      (nRST),
    .rsv_en    (rsv_en),
    .rsv_sel   (rsv_sel),
    .rel_en    (w_commit),
    .rel_sel   (w_sel),
    .flush     (flush),
    .clr_start (w_clr_start),
    .hold      (clr_busy),
    .rsv_ready (rsv_ready),
    .busy      (w_busy)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] w_rsel;
    logic          w_fwd;

    assign w_rsel = rd_sel[gi*AW +: AW];
    // Forward only writes that will actually commit, so dropped writes never leak out.
    assign w_fwd  = (BYPASS != 0) && w_commit && (w_sel == w_rsel);

    assign rd_data[gi*DATA_W +: DATA_W] = (w_rsel == '0) ? '0 :
                                          w_fwd          ? w_data :
                                                           r_regs[w_rsel];
    assign rd_busy[gi] = (w_rsel != '0) && !w_fwd && w_busy[w_rsel];
  end
endmodule

// File: tb/tb_dyt_scoreboard_regfile.sv
// Directed bench: forwarding vs. no-forwarding instances share stimulus; expected values hand-computed.
module tb_dyt_scoreboard_regfile;
  import common_types::*;

  logic        CLK;
  logic        nRST;
  logic [14:0] rd_sel;
  logic [95:0] rd_data, rd_data_nb;
  logic [2:0]  rd_busy, rd_busy_nb;
  logic        wen;
  logic [4:0]  w_sel;
  word_t       w_data;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic        rsv_ready, rsv_ready_nb;
  logic        flush;
  logic        clr_req;
  logic        clr_busy, clr_busy_nb;

  int total = 0;
  int bad   = 0;
  int n;

  dyt_scoreboard_regfile #(.BYPASS(1)) dut (
    .CLK(CLK), .nRST(nRST), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
    .wen(wen), .w_sel(w_sel), .w_data(w_data), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .rsv_ready(rsv_ready), .flush(flush), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  dyt_scoreboard_regfile #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .nRST(nRST), .rd_sel(rd_sel), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wen(wen), .w_sel(w_sel), .w_data(w_data), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .rsv_ready(rsv_ready_nb), .flush(flush), .clr_req(clr_req), .clr_busy(clr_busy_nb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_sel = {a2, a1, a0};
  endtask

  function automatic logic [31:0] port(input logic [95:0] bus, input int i);
    return bus[i*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; rd_sel = '0; wen = 1'b0; w_sel = '0; w_data = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0; clr_req = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 96'h0);
    chk("rst_rd_busy", {93'h0, rd_busy}, 96'h0);
    chk("rst_rsv_ready", {95'h0, rsv_ready}, 96'h1);
    chk("rst_clr_busy", {95'h0, clr_busy}, 96'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // write reg 5, same-cycle and next-cycle reads on port 2
    wen = 1'b1; w_sel = 5'd5; w_data = 32'hDEADBEEF; set_rd(0, 0, 5); #1;
    chk("byp_same_cycle", {64'h0, port(rd_data, 2)}, {64'h0, 32'hDEADBEEF});
    chk("nobyp_same_cycle", {64'h0, port(rd_data_nb, 2)}, 96'h0);
    step(); wen = 1'b0; #1;
    chk("byp_next_cycle", {64'h0, port(rd_data, 2)}, {64'h0, 32'hDEADBEEF});
    chk("nobyp_next_cycle", {64'h0, port(rd_data_nb, 2)}, {64'h0, 32'hDEADBEEF});

    // write to reg 0 is discarded
    wen = 1'b1; w_sel = 5'd0; w_data = 32'hFFFFFFFF; set_rd(0, 0, 0); #1;
    chk("r0_same_cycle", rd_data, 96'h0);
    step(); wen = 1'b0; #1;
    chk("r0_after", rd_data, 96'h0);
    chk("r0_busy", {93'h0, rd_busy}, 96'h0);

    // reservation / WAW stall on reg 7
    rsv_en = 1'b1; rsv_sel = 5'd7; set_rd(7, 0, 0); #1;
    chk("rsv7_first_ready", {95'h0, rsv_ready}, 96'h1);
    step(); #1;
    chk("rsv7_stall", {95'h0, rsv_ready}, 96'h0);
    chk("rsv7_busy", {93'h0, rd_busy}, 96'h1);
    wen = 1'b1; w_sel = 5'd7; w_data = 32'h77; #1;
    chk("rsv7_wr_ready", {95'h0, rsv_ready}, 96'h1);
    chk("rsv7_wr_fwd", {64'h0, port(rd_data, 0)}, 96'h77);
    chk("rsv7_wr_fwd_busy", {93'h0, rd_busy}, 96'h0);
    step(); wen = 1'b0; rsv_en = 1'b0; #1;
    chk("rsv7_busy_kept", {93'h0, rd_busy}, 96'h1);
    chk("rsv7_data", {64'h0, port(rd_data, 0)}, 96'h77);
    wen = 1'b1; w_data = 32'h78; step(); wen = 1'b0; #1;
    chk("rel7_busy", {93'h0, rd_busy}, 96'h0);
    chk("rel7_data", {64'h0, port(rd_data, 0)}, 96'h78);

    // reserve 3,4,9 then flush with reservation of 10 and a concurrent write to 3
    rsv_en = 1'b1;
    rsv_sel = 5'd3; step();
    rsv_sel = 5'd4; step();
    rsv_sel = 5'd9; step();
    rsv_en = 1'b0; set_rd(3, 4, 9); #1;
    chk("three_busy", {93'h0, rd_busy}, 96'h7);
    flush = 1'b1; rsv_en = 1'b1; rsv_sel = 5'd10; wen = 1'b1; w_sel = 5'd3; w_data = 32'h33; #1;
    chk("flush_ready", {95'h0, rsv_ready}, 96'h0);
    step(); flush = 1'b0; rsv_en = 1'b0; wen = 1'b0; #1;
    chk("flush_busy", {93'h0, rd_busy}, 96'h0);
    chk("flush_wr_commit", {64'h0, port(rd_data, 0)}, 96'h33);
    set_rd(10, 0, 0); #1;
    chk("flush_r10_busy", {93'h0, rd_busy}, 96'h0);

    // fill 1..31, reserve 12, then sequential clear
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; w_sel = 5'(i); w_data = 32'(i) * 32'h01010101;
      step();
    end
    wen = 1'b0; rsv_en = 1'b1; rsv_sel = 5'd12; step(); rsv_en = 1'b0;
    set_rd(1, 16, 31); #1;
    chk("fill_values", rd_data, {32'h1F1F1F1F, 32'h10101010, 32'h01010101});
    set_rd(12, 0, 0); #1;
    chk("pre_clr_busy12", {93'h0, rd_busy}, 96'h1);
    clr_req = 1'b1; step(); clr_req = 1'b0;
    wen = 1'b1; w_sel = 5'd20; w_data = 32'hABCD; rsv_en = 1'b1; rsv_sel = 5'd12; #1;
    chk("clr_rsv_ready", {95'h0, rsv_ready}, 96'h0);
    chk("clr_entry_busy12", {93'h0, rd_busy}, 96'h0);
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) clr_req = 1'b1;
      step(); #1;
    end
    clr_req = 1'b0; wen = 1'b0; rsv_en = 1'b0;
    chk("clr_cycles", 96'(n), 96'd31);
    step(); #1;
    chk("clr_req_ignored", {95'h0, clr_busy}, 96'h0);
    set_rd(1, 20, 31); #1;
    chk("clr_reads_zero", rd_data, 96'h0);
    set_rd(16, 2, 30); #1;
    chk("clr_reads_zero2", rd_data, 96'h0);

    // async reset in the middle of a clear
    wen = 1'b1; w_sel = 5'd2; w_data = 32'h22; step();
    w_sel = 5'd30; w_data = 32'h3030; step(); wen = 1'b0;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    for (int c = 1; c < 10; c++) step();
    set_rd(2, 30, 0); #1;
    chk("mid_clr_busy", {95'h0, clr_busy}, 96'h1);
    chk("mid_clr_r30", {64'h0, port(rd_data, 1)}, 96'h3030);
    nRST = 1'b0; #1;
    chk("arst_clr_busy", {95'h0, clr_busy}, 96'h0);
    chk("arst_reads", rd_data, 96'h0);
    @(negedge CLK); nRST = 1'b1;
    step(); #1;
    chk("post_rst_clr_busy", {95'h0, clr_busy}, 96'h0);
    chk("post_rst_reads", rd_data, 96'h0);
    chk("post_rst_ready", {95'h0, rsv_ready}, 96'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
